// File: rtl/div_unsigned_iter.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Define DIV_ERR_CHECK_EN to flag divide-by-zero / quotient overflow at accept.
module div_unsigned_iter #(
   parameter int WIDTHA = 16,
   parameter int WIDTHB = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTHA+WIDTHB-1:0] DIVIDEND,
   input  logic [WIDTHB-1:0]        DIVISOR,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTHA-1:0]        QUO,
   output logic [WIDTHB-1:0]        REM,
   output logic                     ERR
);

   localparam int CW = (WIDTHA > 1) ? $clog2(WIDTHA) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_n;
   logic [WIDTHB-1:0] r, r_n;
   logic [WIDTHA-1:0] q, q_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [WIDTHB-1:0] dvs, dvs_n;
   logic [WIDTHB:0]   t;
   logic [WIDTHB-1:0] diff;
   logic [WIDTHB-1:0] top;
   logic              ge;
   logic              bad;

   assign top  = DIVIDEND[WIDTHA+WIDTHB-1 -: WIDTHB];
   assign t    = {r, q[WIDTHA-1]};
   assign ge   = t >= {1'b0, dvs};
   // Partial remainder stays below the divisor, so the low bits suffice
   assign diff = t[WIDTHB-1:0] - dvs;

`ifdef DIV_ERR_CHECK_EN
   assign bad = (DIVISOR == '0) || (top >= DIVISOR);
`else
   assign bad = 1'b0;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign QUO       = q;
   assign REM       = r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         q     <= '0;
         cnt   <= '0;
         dvs   <= '0;
      end else begin
         state <= state_n;
         r     <= r_n;
         q     <= q_n;
         cnt   <= cnt_n;
         dvs   <= dvs_n;
      end
   end

   always_comb begin
      state_n = state;
      r_n     = r;
      q_n     = q;
      cnt_n   = cnt;
      dvs_n   = dvs;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               dvs_n = DIVISOR;
               if (bad) begin
                  q_n     = '1;
                  r_n     = '0;
                  state_n = DONE;
               end else begin
                  r_n     = top;
                  q_n     = DIVIDEND[WIDTHA-1:0];
                  cnt_n   = CW'(WIDTHA - 1);
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            r_n = ge ? diff : t[WIDTHB-1:0];
            q_n = {q[WIDTHA-2:0], ge};
            if (cnt == '0) state_n = DONE;
            else           cnt_n   = cnt - 1'b1;
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef DIV_ERR_CHECK_EN
   logic err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       err <= 1'b0;
      else if (state == IDLE && in_valid) err <= bad;
   end

   assign ERR = err;
`else
   assign ERR = 1'b0;
`endif

endmodule
